uart_wb_ctrl: RTL and testbench

Wishbone-master sequencer that owns one `uart_top` (16550) instance. After reset it programs the divisor latch, line, FIFO and interrupt-enable registers. It then polls the Line Status Register and moves bytes between simple valid/ready byte streams and the UART's THR/RBR. It lets firmware-free logic use the UART without hand-written bus cycles.

---
 rtl/uart_wb_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_wb_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_ctrl.sv
// uart_wb_ctrl: Wishbone master that configures a 16550 UART after reset and then
// bridges valid/ready byte streams to its THR/RBR by polling the LSR.
//
// state          | meaning
// INIT_LCR_DLAB  | write LCR with DLAB set
// INIT_DL1       | write divisor low byte
// INIT_DL2       | write divisor high byte
// INIT_LCR       | write LCR with DLAB cleared
// INIT_FCR       | write FIFO control
// INIT_IER       | write interrupt enable
// IDLE           | no bus cycle; decide whether to poll
// POLL_LSR       | read line status
// RD_RBR         | read received byte
// WR_THR         | write byte to transmit
module uart_wb_ctrl #(
  parameter logic [15:0] DIVISOR     = 16'd2,
  parameter logic [7:0]  LCR_VAL     = 8'h1B,
  parameter logic [7:0]  FCR_VAL     = 8'hC7,
  parameter logic [7:0]  IER_VAL     = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        reinit,
  output logic        init_done,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    INIT_LCR_DLAB, INIT_DL1, INIT_DL2, INIT_LCR, INIT_FCR, INIT_IER,
    IDLE, POLL_LSR, RD_RBR, WR_THR
  } state_t;

  localparam logic [15:0] TMR_LOAD = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tmr;
  logic        thre_q;
  logic        reinit_pend;
  logic        reinit_req;
  logic        start, done, abort, restart;
  logic [4:0]  tr_adr;
  logic [7:0]  tr_byte;
  logic        tr_we;
  logic [7:0]  rd_byte;

  assign reinit_req = reinit_pend | reinit;
  assign rd_byte    = wb_dat_i[{wb_adr_o[1:0], 3'b000} +: 8];

  always_comb begin
    tr_adr  = 5'd0;
    tr_byte = 8'h00;
    tr_we   = 1'b1;
    case (state)
      INIT_LCR_DLAB: begin tr_adr = 5'd3; tr_byte = LCR_VAL | 8'h80; end
      INIT_DL1:      tr_byte = DIVISOR[7:0];
      INIT_DL2:      begin tr_adr = 5'd1; tr_byte = DIVISOR[15:8]; end
      INIT_LCR:      begin tr_adr = 5'd3; tr_byte = LCR_VAL & 8'h7F; end
      INIT_FCR:      begin tr_adr = 5'd2; tr_byte = FCR_VAL; end
      INIT_IER:      begin tr_adr = 5'd1; tr_byte = IER_VAL; end
      POLL_LSR:      begin tr_adr = 5'd5; tr_we = 1'b0; end
      RD_RBR:        tr_we = 1'b0;
      WR_THR:        tr_byte = tx_data;
      default:       tr_we = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    restart   = 1'b0;
    if (wb_cyc_o) begin
      if (wb_ack_i) begin
        done = 1'b1;
        case (state)
          INIT_LCR_DLAB: state_nxt = INIT_DL1;
          INIT_DL1:      state_nxt = INIT_DL2;
          INIT_DL2:      state_nxt = INIT_LCR;
          INIT_LCR:      state_nxt = INIT_FCR;
          INIT_FCR:      state_nxt = INIT_IER;
          POLL_LSR: begin
            if (rd_byte[0] && !rx_valid)     state_nxt = RD_RBR;
            else if (rd_byte[5] && tx_valid) state_nxt = WR_THR;
            else                             state_nxt = IDLE;
          end
          RD_RBR:  state_nxt = (thre_q && tx_valid) ? WR_THR : IDLE;
          default: state_nxt = IDLE;
        endcase
        restart = reinit_req;
      end else if (tmr == 16'd0) begin
        abort   = 1'b1;
        restart = 1'b1;
      end
    end else if (state == IDLE) begin
      if (reinit_req)                state_nxt = INIT_LCR_DLAB;
      else if (tx_valid || !rx_valid) state_nxt = POLL_LSR;
      restart = reinit_req;
    end else begin
      start = 1'b1;
    end
    if (restart) state_nxt = INIT_LCR_DLAB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_LCR_DLAB;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= 5'd0;
      wb_sel_o    <= 4'd0;
      wb_dat_o    <= 32'd0;
      tmr         <= 16'd0;
      thre_q      <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      init_done   <= 1'b0;
      timeout_err <= 1'b0;
      reinit_pend <= 1'b0;
    end else begin
      if (start) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= tr_we;
        wb_adr_o <= tr_adr;
        wb_sel_o <= 4'b0001 << tr_adr[1:0];
        wb_dat_o <= {24'h0, tr_byte} << {tr_adr[1:0], 3'b000};
        tmr      <= TMR_LOAD;
      end else if (done || abort) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_adr_o <= 5'd0;
        wb_sel_o <= 4'd0;
        wb_dat_o <= 32'd0;
      end else if (wb_cyc_o) begin
        tmr <= tmr - 16'd1;
      end

      if (done && state == POLL_LSR) thre_q <= rd_byte[5];

      if (done && state == RD_RBR) begin
        rx_data  <= rd_byte;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      tx_ready <= done && (state == WR_THR);

      // a restart requested on the IER ack wins over completing init
      if (restart)                       init_done <= 1'b0;
      else if (done && state == INIT_IER) init_done <= 1'b1;

      if (abort) timeout_err <= 1'b1;

      if (restart)     reinit_pend <= 1'b0;
      else if (reinit) reinit_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Directed bench for uart_wb_ctrl: Wishbone slave models answer register accesses,
// and a second pair of controllers exchanges bytes through a THR->RBR byte queue.
`timescale 1ns/1ps
module tb_uart_wb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic        wb_ack = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0, rx_ready = 1'b0, reinit = 1'b0;
  logic [7:0]  rx_data;
  logic        tx_ready, rx_valid, init_done, timeout_err;

  logic [31:0] lsr_val = 32'h0, rbr_val = 32'h0;
  logic        blk_en = 1'b0;
  int          total = 0, bad = 0, cyc_n = 0, txr_cnt = 0;
  logic [41:0] log_q[$];
  int          log_cyc[$];
  logic [41:0] init_exp [6];

  uart_wb_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reinit(reinit), .init_done(init_done), .timeout_err(timeout_err)
  );

  assign wb_dat_i = (wb_adr == 5'd5) ? lsr_val : (wb_adr == 5'd0) ? rbr_val : 32'h0;

  always @(posedge clk) begin
    #1;
    wb_ack = wb_cyc && wb_stb && !(blk_en && wb_we && wb_adr == 5'd0);
  end

  always @(posedge clk) begin
    cyc_n++;
    if (wb_cyc && wb_stb && wb_ack) begin
      log_q.push_back({wb_we, wb_adr, wb_sel, wb_dat_o});
      log_cyc.push_back(cyc_n);
    end
    if (tx_ready) txr_cnt++;
  end

  // loopback pair: A's THR writes (DLAB clear) feed B's RBR through a queue
  logic        lb_rst_n = 1'b0;
  logic [4:0]  a_adr, b_adr;
  logic [31:0] a_dout, b_dout;
  logic [31:0] a_din = 32'h0, b_din = 32'h0;
  logic [3:0]  a_sel, b_sel;
  logic        a_we, a_stb, a_cyc, b_we, b_stb, b_cyc;
  logic        a_ack = 1'b0, b_ack = 1'b0;
  logic [7:0]  a_tx_data = 8'h00, a_rx_data, b_rx_data;
  logic        a_tx_valid = 1'b0, a_tx_ready, a_rx_valid, a_init_done, a_terr;
  logic        b_tx_ready, b_rx_valid, b_init_done, b_terr;
  logic        b_rx_ready = 1'b0;
  logic        a_dlab = 1'b0;
  logic [7:0]  lb_q[$];

  uart_wb_ctrl u_a (
    .clk(clk), .rst_n(lb_rst_n),
    .wb_adr_o(a_adr), .wb_dat_o(a_dout), .wb_dat_i(a_din), .wb_sel_o(a_sel),
    .wb_we_o(a_we), .wb_stb_o(a_stb), .wb_cyc_o(a_cyc), .wb_ack_i(a_ack),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(1'b1),
    .reinit(1'b0), .init_done(a_init_done), .timeout_err(a_terr)
  );

  uart_wb_ctrl u_b (
    .clk(clk), .rst_n(lb_rst_n),
    .wb_adr_o(b_adr), .wb_dat_o(b_dout), .wb_dat_i(b_din), .wb_sel_o(b_sel),
    .wb_we_o(b_we), .wb_stb_o(b_stb), .wb_cyc_o(b_cyc), .wb_ack_i(b_ack),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .reinit(1'b0), .init_done(b_init_done), .timeout_err(b_terr)
  );

  always @(posedge clk) begin
    #1;
    a_ack = a_cyc && a_stb;
    a_din = (a_adr == 5'd5) ? 32'h00006000 : 32'h0;
    b_ack = b_cyc && b_stb;
    if (b_adr == 5'd5)      b_din = {16'h0, (lb_q.size() != 0) ? 8'h61 : 8'h60, 8'h00};
    else if (b_adr == 5'd0) b_din = {24'h0, (lb_q.size() != 0) ? lb_q[0] : 8'h00};
    else                    b_din = 32'h0;
  end

  always @(posedge clk) begin
    if (a_cyc && a_stb && a_ack && a_we) begin
      if (a_adr == 5'd3)                 a_dlab = a_dout[31];
      else if (a_adr == 5'd0 && !a_dlab) lb_q.push_back(a_dout[7:0]);
    end
    if (b_cyc && b_stb && b_ack && !b_we && b_adr == 5'd0 && lb_q.size() != 0)
      void'(lb_q.pop_front());
  end

  function automatic logic [41:0] ent(input logic we, input logic [4:0] a,
                                      input logic [3:0] s, input logic [31:0] d);
    return {we, a, s, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  // which: 0 init_done, 1 tx_ready, 2 rx_valid, 3 both loopback init_done, 4 a_tx_ready, 5 b_rx_valid
  task automatic wait_sig(input int which, input int lim, output bit got, output int at);
    got = 1'b0;
    at  = 0;
    for (int n = 0; n < lim && !got; n++) begin
      tick();
      case (which)
        0: got = (init_done === 1'b1);
        1: got = (tx_ready === 1'b1);
        2: got = (rx_valid === 1'b1);
        3: got = (a_init_done === 1'b1) && (b_init_done === 1'b1);
        4: got = (a_tx_ready === 1'b1);
        default: got = (b_rx_valid === 1'b1);
      endcase
      at = cyc_n;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o} !== 44'h0) begin
      bad++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h, want all 0",
               wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o);
    end
    total++;
    if ({tx_ready, rx_valid, init_done, timeout_err, rx_data} !== 12'h0) begin
      bad++;
      $display("FAIL reset_status: got txr=%b rxv=%b done=%b terr=%b rxd=%h, want all 0",
               tx_ready, rx_valid, init_done, timeout_err, rx_data);
    end
  endtask

  task automatic test_init();
    bit got;
    int at;
    init_exp[0] = ent(1'b1, 5'd3, 4'b1000, 32'h9B000000);
    init_exp[1] = ent(1'b1, 5'd0, 4'b0001, 32'h00000002);
    init_exp[2] = ent(1'b1, 5'd1, 4'b0010, 32'h00000000);
    init_exp[3] = ent(1'b1, 5'd3, 4'b1000, 32'h1B000000);
    init_exp[4] = ent(1'b1, 5'd2, 4'b0100, 32'h00C70000);
    init_exp[5] = ent(1'b1, 5'd1, 4'b0010, 32'h00000000);
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== 5'd3) begin
      bad++;
      $display("FAIL first_stb: got cyc=%b stb=%b adr=%0d, want 1 1 3", wb_cyc, wb_stb, wb_adr);
    end
    wait_sig(0, 200, got, at);
    total++;
    if (!got || log_q.size() < 6) begin
      bad++;
      $display("FAIL init_wait: got done=%b writes=%0d, want 1 and >=6", got, log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_q[i] !== init_exp[i]) begin
          bad++;
          $display("FAIL init_write%0d: got %h want %h", i, log_q[i], init_exp[i]);
        end
      end
      total++;
      if (at !== log_cyc[5]) begin
        bad++;
        $display("FAIL init_done_timing: got edge %0d want %0d", at, log_cyc[5]);
      end
    end
  endtask

  task automatic test_tx();
    bit got;
    int at, base, k;
    logic [41:0] w;
    clear_log();
    base = txr_cnt;
    lsr_val = 32'h00006000;
    tx_data = 8'h81;
    tx_valid = 1'b1;
    wait_sig(1, 60, got, at);
    tx_valid = 1'b0;
    lsr_val = 32'h0;
    repeat (3) tick();
    total++;
    if (!got || txr_cnt - base != 1) begin
      bad++;
      $display("FAIL tx_ready_pulse: got seen=%b cycles=%0d want 1 1", got, txr_cnt - base);
    end
    k = -1;
    foreach (log_q[i]) if (k < 0 && log_q[i][41]) k = i;
    w = (k >= 0) ? log_q[k] : 42'h0;
    total++;
    if (w !== ent(1'b1, 5'd0, 4'b0001, 32'h81)) begin
      bad++;
      $display("FAIL tx_thr_write: got %h want %h", w, ent(1'b1, 5'd0, 4'b0001, 32'h81));
    end
    total++;
    if (k < 1 || log_q[k-1] !== ent(1'b0, 5'd5, 4'b0010, 32'h0)) begin
      bad++;
      $display("FAIL tx_lsr_before: got index %0d want LSR read before THR", k);
    end
    total++;
    if (k < 0 || log_cyc[k] !== at) begin
      bad++;
      $display("FAIL tx_ready_timing: got edge %0d want %0d", at, (k >= 0) ? log_cyc[k] : -1);
    end
  endtask

  task automatic test_rx();
    bit got;
    int at, n_rbr;
    clear_log();
    rx_ready = 1'b0;
    lsr_val = 32'h00000100;
    rbr_val = 32'h00000042;
    wait_sig(2, 60, got, at);
    total++;
    if (!got || rx_data !== 8'h42) begin
      bad++;
      $display("FAIL rx_first: got valid=%b data=%h want 1 42", got, rx_data);
    end
    rbr_val = 32'h00000099;
    repeat (20) tick();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h42) begin
      bad++;
      $display("FAIL rx_hold: got valid=%b data=%h want 1 42", rx_valid, rx_data);
    end
    n_rbr = 0;
    foreach (log_q[i]) if (log_q[i][41:36] == 6'b000000) n_rbr++;
    total++;
    if (n_rbr != 1) begin
      bad++;
      $display("FAIL rx_single_read: got %0d RBR reads want 1", n_rbr);
    end
    lsr_val = 32'h0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rx_accept: got valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_both();
    bit got;
    int at, k;
    clear_log();
    lsr_val = 32'h00006100;
    rbr_val = 32'h00000037;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    wait_sig(1, 60, got, at);
    tx_valid = 1'b0;
    lsr_val = 32'h0;
    k = -1;
    foreach (log_q[i]) if (k < 0 && log_q[i][41]) k = i;
    total++;
    if (!got || k < 2 || log_q[k] !== ent(1'b1, 5'd0, 4'b0001, 32'h55)) begin
      bad++;
      $display("FAIL both_thr: got seen=%b index=%0d want THR write of 55", got, k);
    end
    total++;
    if (k < 2 || log_q[k-1] !== ent(1'b0, 5'd0, 4'b0001, 32'h0)
              || log_q[k-2] !== ent(1'b0, 5'd5, 4'b0010, 32'h0)) begin
      bad++;
      $display("FAIL both_order: got index %0d want LSR, RBR, THR in sequence", k);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h37) begin
      bad++;
      $display("FAIL both_rx: got valid=%b data=%h want 1 37", rx_valid, rx_data);
    end
  endtask

  task automatic test_reinit();
    bit got;
    int at;
    clear_log();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    total++;
    if (init_done !== 1'b0) begin
      bad++;
      $display("FAIL reinit_drop: got init_done=%b want 0", init_done);
    end
    wait_sig(0, 200, got, at);
    total++;
    if (!got || log_q.size() < 6) begin
      bad++;
      $display("FAIL reinit_wait: got done=%b writes=%0d want 1 >=6", got, log_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (log_q[i] !== init_exp[i]) begin
          bad++;
          $display("FAIL reinit_write%0d: got %h want %h", i, log_q[i], init_exp[i]);
        end
      end
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h37) begin
      bad++;
      $display("FAIL reinit_rx_kept: got valid=%b data=%h want 1 37", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit got;
    int at, hi;
    blk_en = 1'b1;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      got = (wb_stb === 1'b1 && wb_we === 1'b1 && wb_adr === 5'd0);
    end
    hi = 0;
    while (got && wb_stb === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    total++;
    if (!got || hi != 16) begin
      bad++;
      $display("FAIL timeout_len: got seen=%b stb cycles=%0d want 16", got, hi);
    end
    total++;
    if (timeout_err !== 1'b1 || wb_cyc !== 1'b0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flags: got terr=%b cyc=%b done=%b want 1 0 0",
               timeout_err, wb_cyc, init_done);
    end
    blk_en = 1'b0;
    clear_log();
    wait_sig(0, 200, got, at);
    total++;
    if (log_q.size() < 1 || log_q[0] !== init_exp[0]) begin
      bad++;
      $display("FAIL timeout_restart: got %h want %h",
               (log_q.size() != 0) ? log_q[0] : 42'h0, init_exp[0]);
    end
    total++;
    if (!got || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got done=%b terr=%b want 1 1", got, timeout_err);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    int at;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      got = (wb_stb === 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (!got || wb_cyc !== 1'b0 || wb_stb !== 1'b0 || timeout_err !== 1'b0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got seen=%b cyc=%b stb=%b terr=%b done=%b want 1 0 0 0 0",
               got, wb_cyc, wb_stb, timeout_err, init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    wait_sig(0, 200, got, at);
    total++;
    if (!got || log_q.size() < 1 || log_q[0] !== init_exp[0]) begin
      bad++;
      $display("FAIL async_restart: got done=%b first=%h want 1 %h", got,
               (log_q.size() != 0) ? log_q[0] : 42'h0, init_exp[0]);
    end
  endtask

  task automatic test_loopback();
    bit got;
    int at;
    logic [7:0] exp_b;
    @(negedge clk);
    lb_rst_n = 1'b1;
    wait_sig(3, 200, got, at);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL lb_init: got a_done=%b b_done=%b want 1 1", a_init_done, b_init_done);
    end
    for (int i = 0; i < 2; i++) begin
      a_tx_data = (i == 0) ? 8'h81 : 8'h42;
      a_tx_valid = 1'b1;
      wait_sig(4, 60, got, at);
      a_tx_valid = 1'b0;
      total++;
      if (!got) begin
        bad++;
        $display("FAIL lb_send%0d: got tx_ready=0 want 1", i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_b = (i == 0) ? 8'h81 : 8'h42;
      wait_sig(5, 60, got, at);
      total++;
      if (!got || b_rx_data !== exp_b) begin
        bad++;
        $display("FAIL lb_recv%0d: got valid=%b data=%h want 1 %h", i, got, b_rx_data, exp_b);
      end
      b_rx_ready = 1'b1;
      tick();
      b_rx_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_rx();
    test_both();
    test_reinit();
    test_timeout();
    test_async_reset();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
